// File: rtl/bcd_pkg.sv
// bcd_pkg: shared FSM states and BCD/decimal widths for the scan decoder
package bcd_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam int BCD_W = 4;
    localparam int BCD_MAX = 9;
    localparam int DEC_W = 10;
endpackage

// File: rtl/bcd_digit_decode.sv
// bcd_digit_decode: one BCD nibble to a one-hot decimal code plus an invalid-code flag
module bcd_digit_decode
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] nibble,
    output logic [DEC_W-1:0] onehot,
    output logic             invalid
);
    always_comb begin
        invalid = nibble > BCD_W'(BCD_MAX);
        onehot = invalid ? '0 : DEC_W'(1) << nibble;
    end
endmodule

// File: rtl/bcd_scan_decoder.sv
// bcd_scan_decoder: scans a captured BCD word MS-first, one held one-hot digit at a time
module bcd_scan_decoder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int BLANK_LEADING = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_word,
    output logic                  out_valid,
    output logic [DEC_W-1:0]      dec_onehot,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  digit_err,
    output logic                  blank,
    output logic                  done,
    output logic                  frame_err
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    state_t state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [HW-1:0] hold, hold_n;
    logic [4*DIGITS-1:0] word, word_n, shifted;
    logic lz, lz_n, err, err_n;
    logic [BCD_W-1:0] nib;
    logic [DEC_W-1:0] dec;
    logic inv, scan, last_hold;

    bcd_digit_decode u_dec (
        .nibble  (nib),
        .onehot  (dec),
        .invalid (inv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            hold <= '0;
            word <= '0;
            lz <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            hold <= hold_n;
            word <= word_n;
            lz <= lz_n;
            err <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n = idx;
        hold_n = hold;
        word_n = word;
        lz_n = lz;
        err_n = err;
        case (state)
            IDLE: if (in_valid) begin
                state_n = SCAN;
                word_n = bcd_word;
                idx_n = IW'(DIGITS - 1);
                hold_n = '0;
                err_n = 1'b0;
                lz_n = BLANK_LEADING != 0;
            end
            SCAN: begin
                err_n = err | inv;
                lz_n = lz && nib == '0;
                hold_n = last_hold ? '0 : hold + HW'(1);
                idx_n = last_hold && idx != '0 ? idx - IW'(1) : idx;
                state_n = last_hold && idx == '0 ? DONE : SCAN;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        shifted = word >> (BCD_W * int'(idx));
        nib = shifted[BCD_W-1:0];
        scan = state == SCAN;
        last_hold = hold == HW'(HOLD_CYCLES - 1);
        in_ready = state == IDLE && !rst;
        out_valid = scan;
        blank = BLANK_LEADING != 0 && scan && lz && nib == '0 && idx != '0;
        digit_err = scan && inv;
        dec_onehot = scan && !blank ? dec : '0;
        digit_sel = scan ? DIGITS'(1) << idx : '0;
        done = state == DONE;
        frame_err = done && err;
    end
endmodule
